// File: rtl/w_schedule_if.sv
// Stream bundle for the SHA-256 message-schedule generator: message-word input
// port, W-word output port and the busy status flag.
interface w_schedule_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_out;
   logic [5:0]  w_index;
   logic        w_last;
   logic        busy;

   modport master (
      output in_valid, in_word, w_ready,
      input  in_ready, w_valid, w_out, w_index, w_last, busy
   );

   modport slave (
      input  in_valid, in_word, w_ready,
      output in_ready, w_valid, w_out, w_index, w_last, busy
   );
endinterface

// File: rtl/w_schedule.sv
// SHA-256 message schedule: loads 16 message words, then streams W[0..NUM_ROUNDS-1]
// from a 16-entry sliding window, one word per accepted handshake.
module w_schedule #(
   parameter int unsigned NUM_ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   w_schedule_if.slave  bus
);

   localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

   generate
      if (NUM_ROUNDS < 16 || NUM_ROUNDS > 64) begin : g_bad_rounds
         $error("w_schedule: NUM_ROUNDS must be within 16..64");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] win [16];
   logic [3:0]  load_cnt;
   logic [5:0]  t_idx;
   logic        in_ready_r;
   logic        w_valid_r;
   logic        w_last_r;
   logic        busy_r;
   logic [31:0] w_next;

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Window slot k holds W[t+k], so W[t+16] taps slots 14, 9, 1 and 0.
   always_comb begin
      w_next = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready_r <= 1'b0;
         w_valid_r  <= 1'b0;
         w_last_r   <= 1'b0;
         busy_r     <= 1'b0;
         load_cnt   <= '0;
         t_idx      <= '0;
         for (int unsigned i = 0; i < 16; i++) begin
            win[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               state      <= LOAD;
               in_ready_r <= 1'b1;
               busy_r     <= 1'b1;
               load_cnt   <= '0;
            end

            LOAD: begin
               if (bus.in_valid) begin
                  win[load_cnt] <= bus.in_word;
                  load_cnt      <= load_cnt + 4'd1;
                  if (load_cnt == 4'd15) begin
                     state      <= RUN;
                     in_ready_r <= 1'b0;
                     w_valid_r  <= 1'b1;
                     w_last_r   <= 1'b0;
                     t_idx      <= '0;
                  end
               end
            end

            RUN: begin
               if (bus.w_ready) begin
                  for (int unsigned i = 0; i < 15; i++) begin
                     win[i] <= win[i+1];
                  end
                  win[15] <= w_next;
                  if (w_last_r) begin
                     state      <= LOAD;
                     in_ready_r <= 1'b1;
                     w_valid_r  <= 1'b0;
                     w_last_r   <= 1'b0;
                     load_cnt   <= '0;
                     t_idx      <= '0;
                  end else begin
                     t_idx    <= t_idx + 6'd1;
                     w_last_r <= (t_idx == LAST_IDX - 6'd1);
                  end
               end
            end

            default: begin
               state      <= IDLE;
               in_ready_r <= 1'b0;
               w_valid_r  <= 1'b0;
               w_last_r   <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.w_valid  = w_valid_r;
   assign bus.w_out    = win[0];
   assign bus.w_index  = t_idx;
   assign bus.w_last   = w_last_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_w_schedule.sv
// Directed bench for w_schedule: 64-round instance for the main scenarios plus a
// 16-round instance, checked against an independent FIPS-style schedule model.
module tb_w_schedule;

   typedef logic [31:0] word_t;

   logic  clk = 1'b0;
   logic  rst;
   logic  drv_valid;
   word_t drv_word;
   logic  drv_ready;
   logic  drv_ready16;

   int n_vec = 0;
   int n_err = 0;

   word_t abc_blk  [16];
   word_t zero_blk [16];
   word_t ff_blk   [16];
   word_t got      [64];

   always #5 clk = ~clk;

   w_schedule_if bus64 ();
   w_schedule_if bus16 ();

   assign bus64.in_valid = drv_valid;
   assign bus64.in_word  = drv_word;
   assign bus64.w_ready  = drv_ready;
   assign bus16.in_valid = drv_valid;
   assign bus16.in_word  = drv_word;
   assign bus16.w_ready  = drv_ready16;

   w_schedule #(.NUM_ROUNDS(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
   w_schedule #(.NUM_ROUNDS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic word_t ss0(input word_t x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction

   function automatic word_t ss1(input word_t x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction

   function automatic void gen_w(input word_t m [16], output word_t w [64]);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else        w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
      end
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wv"},  {31'b0, bus64.w_valid}, 32'd0);
      check({tag, "_ir"},  {31'b0, bus64.in_ready}, 32'd0);
      check({tag, "_idx"}, {26'b0, bus64.w_index}, 32'd0);
      check({tag, "_lst"}, {31'b0, bus64.w_last}, 32'd0);
      check({tag, "_bsy"}, {31'b0, bus64.busy}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      drv_valid = 1'b0;
      drv_ready = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst");
      check("rst_wout", bus64.w_out, 32'd0);
      rst = 1'b0;
   endtask

   // Offers up to n words; with gap set, in_valid is only high every 3rd cycle.
   task automatic load_block(input word_t m [16], input bit gap, input int n);
      int cnt = 0;
      int cyc = 0;
      bit saw_wv = 1'b0;
      while (cnt < n && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (bus64.w_valid) saw_wv = 1'b1;
         if (gap && (cyc % 3 != 0)) begin
            drv_valid = 1'b0;
            drv_word  = 'x;
         end else begin
            drv_valid = 1'b1;
            drv_word  = m[cnt];
            if (bus64.in_ready) cnt++;
         end
      end
      check("load_cnt", cnt, n);
      check("load_nowv", {31'b0, saw_wv}, 32'd0);
   endtask

   // Consumes the block; abort >= 0 asserts rst when w_index reaches that value.
   task automatic run_block(input word_t m [16], input bit rnd, input bit hold,
                            input int abort, output word_t gw [64]);
      word_t w [64];
      int    idx = 0;
      int    cyc = 0;
      bit    stalled = 1'b0;
      bit    first = 1'b1;
      word_t held_out = '0;
      logic [5:0] held_idx = '0;
      gen_w(m, w);
      for (int k = 0; k < 64; k++) gw[k] = '0;
      while (idx < 64 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (first) begin
            check("w0_valid", {31'b0, bus64.w_valid}, 32'd1);
            check("w0_inrdy", {31'b0, bus64.in_ready}, 32'd0);
            check("w0_busy",  {31'b0, bus64.busy}, 32'd1);
            first = 1'b0;
         end
         if (stalled) begin
            check("hold_out", bus64.w_out, held_out);
            check("hold_idx", {26'b0, bus64.w_index}, {26'b0, held_idx});
         end
         if (abort == idx) begin
            check("abort_idx", {26'b0, bus64.w_index}, abort);
            rst       = 1'b1;
            drv_valid = 1'b0;
            drv_ready = 1'b0;
            @(negedge clk);
            check_reset_outputs("abort");
            rst = 1'b0;
            return;
         end
         drv_valid = hold;
         drv_word  = 32'hDEADBEEF;
         drv_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus64.w_valid && drv_ready) begin
            check("w_out", bus64.w_out, w[idx]);
            check("w_index", {26'b0, bus64.w_index}, idx);
            check("w_last", {31'b0, bus64.w_last}, {31'b0, (idx == 63)});
            gw[idx] = bus64.w_out;
            idx++;
            stalled = 1'b0;
         end else begin
            stalled  = bus64.w_valid;
            held_out = bus64.w_out;
            held_idx = bus64.w_index;
         end
      end
      check("run_cnt", idx, 64);
      @(negedge clk);
      drv_valid = 1'b0;
      drv_ready = 1'b0;
      check("end_wv", {31'b0, bus64.w_valid}, 32'd0);
      check("end_inrdy", {31'b0, bus64.in_ready}, 32'd1);
   endtask

   task automatic run16(input word_t m [16]);
      word_t w [64];
      int i = 0;
      gen_w(m, w);
      for (int c = 0; c < 40 && i < 16; c++) begin
         @(negedge clk);
         drv_ready16 = 1'b1;
         if (bus16.w_valid) begin
            check("n16_out", bus16.w_out, w[i]);
            check("n16_idx", {26'b0, bus16.w_index}, i);
            check("n16_last", {31'b0, bus16.w_last}, {31'b0, (i == 15)});
            i++;
         end
      end
      check("n16_cnt", i, 16);
      @(negedge clk);
      check("n16_end", {31'b0, bus16.w_valid}, 32'd0);
      check("n16_inrdy", {31'b0, bus16.in_ready}, 32'd1);
      drv_ready16 = 1'b0;
   endtask

   initial begin
      word_t g16 [64];
      for (int i = 0; i < 16; i++) begin
         abc_blk[i]  = '0;
         zero_blk[i] = '0;
         ff_blk[i]   = 32'hFFFFFFFF;
      end
      abc_blk[0]  = 32'h61626380;
      abc_blk[15] = 32'h00000018;

      rst         = 1'b1;
      drv_valid   = 1'b0;
      drv_word    = '0;
      drv_ready   = 1'b0;
      drv_ready16 = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("init");
      check("init_wout", bus64.w_out, 32'd0);
      rst = 1'b0;

      // "abc" with hand-computed words
      load_block(abc_blk, 1'b0, 16);
      run_block(abc_blk, 1'b0, 1'b0, -1, got);
      check("abc_w0",  got[0],  32'h61626380);
      check("abc_w15", got[15], 32'h00000018);
      check("abc_w16", got[16], 32'h61626380);
      check("abc_w17", got[17], 32'h000F0000);

      load_block(zero_blk, 1'b0, 16);
      run_block(zero_blk, 1'b0, 1'b0, -1, got);

      load_block(abc_blk, 1'b0, 16);
      run_block(abc_blk, 1'b1, 1'b0, -1, got);

      // gapped load, in_valid held high through RUN, then a clean block
      load_block(abc_blk, 1'b1, 16);
      run_block(abc_blk, 1'b0, 1'b1, -1, got);
      load_block(zero_blk, 1'b0, 16);
      run_block(zero_blk, 1'b0, 1'b0, -1, got);

      // resets mid-load and mid-run
      load_block(ff_blk, 1'b0, 8);
      do_reset();
      load_block(ff_blk, 1'b0, 16);
      run_block(ff_blk, 1'b0, 1'b0, 30, got);
      load_block(abc_blk, 1'b0, 16);
      run_block(abc_blk, 1'b0, 1'b0, -1, got);

      // back-to-back blocks
      load_block(abc_blk, 1'b0, 16);
      run_block(abc_blk, 1'b0, 1'b0, -1, got);
      load_block(ff_blk, 1'b0, 16);
      run_block(ff_blk, 1'b1, 1'b0, -1, got);

      // 16-round instance alongside the 64-round one
      do_reset();
      load_block(abc_blk, 1'b0, 16);
      fork
         run_block(abc_blk, 1'b0, 1'b0, -1, g16);
         run16(abc_blk);
      join

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
